// File: rtl/instr_decoder.sv
// Decode stage: turns 9-bit instructions into registered ALU/regfile/memory/branch
// controls, sequences LOAD/STORE against mem_ack with a timeout, and latches HALT.
module instr_decoder #(
  parameter int MEM_TIMEOUT = 15,
  parameter int REG_AW      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_valid,
  input  logic [8:0]        inst,
  output logic              inst_ready,
  input  logic              flag_eq,
  input  logic              flag_gt,
  input  logic              mem_ack,
  output logic              ctrl_valid,
  output logic              alu_en,
  output logic [2:0]        alu_op,
  output logic [REG_AW-1:0] reg_addr,
  output logic [3:0]        imm,
  output logic              reg_we,
  output logic              mem_re,
  output logic              mem_we,
  output logic              branch_taken,
  output logic              branch_rel,
  output logic              mem_err,
  output logic              illegal,
  output logic              halted
);

  localparam logic [2:0] K_CMP   = 3'b100;
  localparam logic [1:0] K_MOVE  = 2'b00;
  localparam logic [1:0] K_FLAG  = 2'b01;
  localparam logic [1:0] K_LOAD  = 2'b10;
  localparam logic [1:0] K_STORE = 2'b11;
  localparam logic [2:0] K_BEA = 3'b000, K_BER = 3'b001, K_BNA = 3'b010;
  localparam logic [2:0] K_BNR = 3'b011, K_BUN = 3'b100, K_BGT = 3'b101;
  localparam logic [8:0] K_HALT = 9'h1FF;
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, HALTED = 2'd2} state_t;

  state_t            state, state_nx;
  logic [7:0]        cnt, cnt_nx;
  logic              ctrl_valid_nx, alu_en_nx, reg_we_nx, mem_re_nx, mem_we_nx;
  logic              branch_taken_nx, branch_rel_nx, mem_err_nx, illegal_nx;
  logic [2:0]        alu_op_nx;
  logic [REG_AW-1:0] reg_addr_nx;
  logic [3:0]        imm_nx;

  assign inst_ready = (state == RUN);
  assign halted     = (state == HALTED);

  always_comb begin
    state_nx        = state;
    cnt_nx          = cnt;
    ctrl_valid_nx   = 1'b0;
    illegal_nx      = 1'b0;
    mem_err_nx      = 1'b0;
    alu_en_nx       = alu_en;
    alu_op_nx       = alu_op;
    reg_addr_nx     = reg_addr;
    imm_nx          = imm;
    reg_we_nx       = reg_we;
    mem_re_nx       = mem_re;
    mem_we_nx       = mem_we;
    branch_taken_nx = branch_taken;
    branch_rel_nx   = branch_rel;
    case (state)
      RUN: begin
        if (inst_valid) begin
          // Every accepted word starts from a NOP so no control leaks from the previous decode.
          ctrl_valid_nx   = 1'b1;
          alu_en_nx       = 1'b0;
          alu_op_nx       = 3'b000;
          reg_addr_nx     = '0;
          imm_nx          = 4'h0;
          reg_we_nx       = 1'b0;
          mem_re_nx       = 1'b0;
          mem_we_nx       = 1'b0;
          branch_taken_nx = 1'b0;
          branch_rel_nx   = 1'b0;
          case (inst[8:7])
            2'b00: begin
              alu_en_nx   = 1'b1;
              alu_op_nx   = inst[6:4];
              reg_addr_nx = REG_AW'(inst[3:1]);
              imm_nx      = inst[3:0];
              reg_we_nx   = (inst[6:4] != K_CMP);
            end
            2'b01: begin
              reg_addr_nx = REG_AW'(inst[4:2]);
              reg_we_nx   = (inst[6:5] == K_MOVE) || (inst[6:5] == K_LOAD);
              mem_re_nx   = (inst[6:5] == K_LOAD);
              mem_we_nx   = (inst[6:5] == K_STORE);
              if (inst[6:5] == K_LOAD || inst[6:5] == K_STORE) begin
                state_nx = MEM_WAIT;
                cnt_nx   = 8'd0;
              end else begin
                state_nx = RUN;
              end
            end
            2'b10: begin
              imm_nx = inst[3:0];
              case (inst[6:4])
                K_BEA:   branch_taken_nx = flag_eq;
                K_BER:   begin branch_taken_nx = flag_eq;  branch_rel_nx = 1'b1; end
                K_BNA:   branch_taken_nx = !flag_eq;
                K_BNR:   begin branch_taken_nx = !flag_eq; branch_rel_nx = 1'b1; end
                K_BUN:   begin branch_taken_nx = 1'b1;     branch_rel_nx = 1'b1; end
                K_BGT:   begin branch_taken_nx = flag_gt;  branch_rel_nx = 1'b1; end
                default: begin illegal_nx = 1'b1; imm_nx = 4'h0; end
              endcase
            end
            default: begin
              if (inst == K_HALT) begin
                state_nx = HALTED;
              end else begin
                illegal_nx = 1'b1;
              end
            end
          endcase
        end else begin
          state_nx = RUN;
        end
      end
      MEM_WAIT: begin
        cnt_nx = cnt + 8'd1;
        // An ack in the timeout cycle still counts as success.
        if (mem_ack) begin
          state_nx  = RUN;
          mem_re_nx = 1'b0;
          mem_we_nx = 1'b0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nx   = RUN;
          mem_err_nx = 1'b1;
          mem_re_nx  = 1'b0;
          mem_we_nx  = 1'b0;
        end else begin
          state_nx = MEM_WAIT;
        end
      end
      HALTED:  state_nx = HALTED;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      cnt          <= 8'd0;
      ctrl_valid   <= 1'b0;
      alu_en       <= 1'b0;
      alu_op       <= 3'b000;
      reg_addr     <= '0;
      imm          <= 4'h0;
      reg_we       <= 1'b0;
      mem_re       <= 1'b0;
      mem_we       <= 1'b0;
      branch_taken <= 1'b0;
      branch_rel   <= 1'b0;
      mem_err      <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      ctrl_valid   <= ctrl_valid_nx;
      alu_en       <= alu_en_nx;
      alu_op       <= alu_op_nx;
      reg_addr     <= reg_addr_nx;
      imm          <= imm_nx;
      reg_we       <= reg_we_nx;
      mem_re       <= mem_re_nx;
      mem_we       <= mem_we_nx;
      branch_taken <= branch_taken_nx;
      branch_rel   <= branch_rel_nx;
      mem_err      <= mem_err_nx;
      illegal      <= illegal_nx;
    end
  end

endmodule
